// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: select codes, opcodes and funct7 values.
package alu_issue_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SLL = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_AND = 4'd7;
    localparam logic [3:0] ALU_SUB = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd13;
    localparam logic [3:0] ALU_MUL = 4'd15;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32 decode into ALU select, immediate operand and destination register.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic [31:0]       i_instr,
    output logic [SEL_W-1:0]  o_sel,
    output logic [DATA_W-1:0] o_imm,
    output logic              o_use_imm,
    output logic [4:0]        o_rd,
    output logic              o_illegal
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [DATA_W-1:0] w_imm_i;
    logic [DATA_W-1:0] w_imm_s;
    logic [DATA_W-1:0] w_shamt;
    logic [3:0]        w_sel;
    logic              w_unused_rs1_idx;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_imm_i  = {{(DATA_W-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{(DATA_W-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_shamt  = {{(DATA_W-5){1'b0}}, i_instr[24:20]};
    // rs1 index is resolved by the register file upstream.
    assign w_unused_rs1_idx = ^i_instr[19:15];

    always_comb begin
        w_sel     = ALU_ADD;
        o_imm     = '0;
        o_use_imm = 1'b0;
        o_rd      = i_instr[11:7];
        o_illegal = 1'b0;
        case (w_opcode)
            OP_R: begin
                if (w_f7 == F7_BASE && w_f3 != 3'd3)     w_sel = {1'b0, w_f3};
                else if (w_f7 == F7_ALT && w_f3 == 3'd0) w_sel = ALU_SUB;
                else if (w_f7 == F7_ALT && w_f3 == 3'd5) w_sel = ALU_SRA;
                else if (w_f7 == F7_MUL && w_f3 == 3'd0) w_sel = ALU_MUL;
                else                                     o_illegal = 1'b1;
            end
            OP_I: begin
                o_use_imm = 1'b1;
                o_imm     = w_imm_i;
                case (w_f3)
                    3'd1: begin
                        o_imm = w_shamt;
                        if (w_f7 == F7_BASE) w_sel = ALU_SLL;
                        else                 o_illegal = 1'b1;
                    end
                    3'd5: begin
                        o_imm = w_shamt;
                        if (w_f7 == F7_BASE)     w_sel = ALU_SRL;
                        else if (w_f7 == F7_ALT) w_sel = ALU_SRA;
                        else                     o_illegal = 1'b1;
                    end
                    3'd3:    o_illegal = 1'b1;
                    default: w_sel = {1'b0, w_f3};
                endcase
            end
            OP_LOAD: begin
                o_use_imm = 1'b1;
                o_imm     = w_imm_i;
            end
            OP_STORE: begin
                o_use_imm = 1'b1;
                o_imm     = w_imm_s;
                o_rd      = 5'd0;
            end
            default: o_illegal = 1'b1;
        endcase
        if (o_illegal) begin
            w_sel     = ALU_ADD;
            o_imm     = '0;
            o_use_imm = 1'b0;
            o_rd      = 5'd0;
        end
    end

    assign o_sel = SEL_W'(w_sel);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue stage: decodes an instruction and presents a registered ALU command
// through a main register backed by a one-entry skid buffer.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs1,
    output logic [DATA_W-1:0] out_rs2,
    output logic [SEL_W-1:0]  out_alusel,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    logic [SEL_W-1:0]  w_sel;
    logic [DATA_W-1:0] w_imm;
    logic              w_use_imm;
    logic [4:0]        w_rd;
    logic              w_illegal;
    logic [DATA_W-1:0] w_rs1;
    logic [DATA_W-1:0] w_rs2;
    logic              w_accept;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_rs1;
    logic [DATA_W-1:0] r_out_rs2;
    logic [SEL_W-1:0]  r_out_sel;
    logic [4:0]        r_out_rd;
    logic              r_out_ill;

    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_rs1;
    logic [DATA_W-1:0] r_skid_rs2;
    logic [SEL_W-1:0]  r_skid_sel;
    logic [4:0]        r_skid_rd;
    logic              r_skid_ill;

    alu_issue_decode #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_decode (
        .i_instr   (in_instr),
        .o_sel     (w_sel),
        .o_imm     (w_imm),
        .o_use_imm (w_use_imm),
        .o_rd      (w_rd),
        .o_illegal (w_illegal)
    );

    assign w_rs1    = w_illegal ? '0 : in_rs1_data;
    assign w_rs2    = w_illegal ? '0 : (w_use_imm ? w_imm : in_rs2_data);
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && !r_skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_rs1    <= '0;
            r_out_rs2    <= '0;
            r_out_sel    <= '0;
            r_out_rd     <= '0;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_rs1   <= '0;
            r_skid_rs2   <= '0;
            r_skid_sel   <= '0;
            r_skid_rd    <= '0;
            r_skid_ill   <= 1'b0;
        end else if (r_skid_valid) begin
            // Skid full implies main full; refill main from skid once it drains.
            if (out_ready) begin
                r_out_rs1    <= r_skid_rs1;
                r_out_rs2    <= r_skid_rs2;
                r_out_sel    <= r_skid_sel;
                r_out_rd     <= r_skid_rd;
                r_out_ill    <= r_skid_ill;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid || out_ready) begin
                r_out_valid <= 1'b1;
                r_out_rs1   <= w_rs1;
                r_out_rs2   <= w_rs2;
                r_out_sel   <= w_sel;
                r_out_rd    <= w_rd;
                r_out_ill   <= w_illegal;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_rs1   <= w_rs1;
                r_skid_rs2   <= w_rs2;
                r_skid_sel   <= w_sel;
                r_skid_rd    <= w_rd;
                r_skid_ill   <= w_illegal;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_rs1     = r_out_rs1;
    assign out_rs2     = r_out_rs2;
    assign out_alusel  = r_out_sel;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed decode vectors, back-pressure,
// randomized traffic against a queue-based reference, and asynchronous reset.
module tb_alu_issue_ctrl;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = '0;
    logic [DATA_W-1:0] in_rs1_data = '0;
    logic [DATA_W-1:0] in_rs2_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_rs1;
    logic [DATA_W-1:0] out_rs2;
    logic [SEL_W-1:0]  out_alusel;
    logic [4:0]        out_rd;
    logic              out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        ill;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } cmd_t;

    cmd_t q[$];
    logic [74:0] obs;
    logic [74:0] exp_obs;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_alusel  (out_alusel),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    // Reference: what the execute stage should see for one instruction.
    function automatic cmd_t ref_cmd(input logic [31:0] instr, input logic [31:0] rs1,
                                     input logic [31:0] rs2);
        cmd_t c;
        logic ok;
        logic [6:0] op = instr[6:0];
        logic [2:0] f3 = instr[14:12];
        logic [6:0] f7 = instr[31:25];
        logic [31:0] imm_i = {{20{instr[31]}}, instr[31:20]};
        c = '0;
        ok = 1'b1;
        c.a = rs1;
        c.rd = instr[11:7];
        case (op)
            7'h33: begin
                c.b = rs2;
                if (f7 == 7'h00 && f3 != 3'd3)      c.sel = {1'b0, f3};
                else if (f7 == 7'h20 && f3 == 3'd0) c.sel = 4'd8;
                else if (f7 == 7'h20 && f3 == 3'd5) c.sel = 4'd13;
                else if (f7 == 7'h01 && f3 == 3'd0) c.sel = 4'd15;
                else                                ok = 1'b0;
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    c.b = {27'd0, instr[24:20]};
                    if (f3 == 3'd1 && f7 == 7'h00)      c.sel = 4'd1;
                    else if (f3 == 3'd5 && f7 == 7'h00) c.sel = 4'd5;
                    else if (f3 == 3'd5 && f7 == 7'h20) c.sel = 4'd13;
                    else                                ok = 1'b0;
                end else if (f3 == 3'd3) begin
                    ok = 1'b0;
                end else begin
                    c.sel = {1'b0, f3};
                    c.b = imm_i;
                end
            end
            7'h03: c.b = imm_i;
            7'h23: begin
                c.b = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                c.rd = 5'd0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c = '0;
            c.ill = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 5))
            0: begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 2))
                    0:       w[31:25] = 7'h00;
                    1:       w[31:25] = 7'h20;
                    default: w[31:25] = 7'h01;
                endcase
            end
            1: w[6:0] = 7'h33;
            2: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            3: w[6:0] = 7'h03;
            4: w[6:0] = 7'h23;
            default: ;
        endcase
        return w;
    endfunction

    task automatic issue_one(input logic [31:0] instr, input logic [31:0] rs1,
                             input logic [31:0] rs2);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        obs = {out_valid, out_illegal, out_alusel, out_rs1, out_rs2, out_rd};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, in_ready, out_illegal, out_alusel, out_rs1, out_rs2, out_rd} !==
            {1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b rdy=%0b ill=%0b sel=%0d rd=%0d want v=0 rdy=1 ill=0 sel=0 rd=0",
                     out_valid, in_ready, out_illegal, out_alusel, out_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] instrs [6] = '{32'h002081B3, 32'h40335293, 32'h022081B3, 32'hFFF00093,
                                    32'h0020B1B3, 32'hFE112E23};
        logic [31:0] rs1s [6] = '{32'd5, 32'h80000000, 32'd9, 32'd0, 32'd4, 32'h100};
        logic [31:0] rs2s [6] = '{32'd7, 32'd1234, 32'd6, 32'd55, 32'd3, 32'd77};
        logic [74:0] exps [6] = '{
            {1'b1, 1'b0, 4'd0,  32'd5,         32'd7,         5'd3},
            {1'b1, 1'b0, 4'd13, 32'h80000000,  32'd3,         5'd5},
            {1'b1, 1'b0, 4'd15, 32'd9,         32'd6,         5'd3},
            {1'b1, 1'b0, 4'd0,  32'd0,         32'hFFFFFFFF,  5'd1},
            {1'b1, 1'b1, 4'd0,  32'd0,         32'd0,         5'd0},
            {1'b1, 1'b0, 4'd0,  32'h100,       32'hFFFFFFFC,  5'd0}};
        for (int i = 0; i < 6; i++) begin
            issue_one(instrs[i], rs1s[i], rs2s[i]);
            n_checks++;
            if (obs !== exps[i]) begin
                n_fail++;
                $display("FAIL decode_%08h: got %h want %h", instrs[i], obs, exps[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [74:0] add_exp = {1'b1, 1'b0, 4'd0, 32'd11, 32'd22, 5'd3};
        logic [74:0] sub_exp = {1'b1, 1'b0, 4'd8, 32'd33, 32'd44, 5'd3};
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        in_rs1_data = 32'd11;
        in_rs2_data = 32'd22;
        @(negedge clk);
        obs = {out_valid, out_illegal, out_alusel, out_rs1, out_rs2, out_rd};
        n_checks++;
        if (obs !== add_exp || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: got %h rdy=%0b want %h rdy=1", obs, in_ready, add_exp);
        end
        in_instr = 32'h402081B3;
        in_rs1_data = 32'd33;
        in_rs2_data = 32'd44;
        @(negedge clk);
        obs = {out_valid, out_illegal, out_alusel, out_rs1, out_rs2, out_rd};
        n_checks++;
        if (obs !== add_exp || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_skid_full: got %h rdy=%0b want %h rdy=0", obs, in_ready, add_exp);
        end
        // Offered while in_ready is low: must be dropped.
        in_instr = 32'h0020C1B3;
        in_rs1_data = 32'd99;
        @(negedge clk);
        obs = {out_valid, out_illegal, out_alusel, out_rs1, out_rs2, out_rd};
        n_checks++;
        if (obs !== add_exp || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored_input: got %h rdy=%0b want %h rdy=0", obs, in_ready, add_exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        obs = {out_valid, out_illegal, out_alusel, out_rs1, out_rs2, out_rd};
        n_checks++;
        if (obs !== sub_exp || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: got %h rdy=%0b want %h rdy=1", obs, in_ready, sub_exp);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drained: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        bit acc;
        cmd_t c;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (q.size() == 0) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_idle cyc=%0d: got v=%0b rdy=%0b want v=0 rdy=1",
                             cyc, out_valid, in_ready);
                end
            end else begin
                c = q[0];
                obs = {out_valid, out_illegal, out_alusel, out_rs1, out_rs2, out_rd};
                exp_obs = {1'b1, c.ill, c.sel, c.a, c.b, c.rd};
                if (obs !== exp_obs || in_ready !== (q.size() < 2)) begin
                    n_fail++;
                    $display("FAIL rand_cmd cyc=%0d: got %h rdy=%0b want %h rdy=%0b",
                             cyc, obs, in_ready, exp_obs, q.size() < 2);
                end
            end
            in_valid = ($urandom_range(0, 99) < 70);
            in_instr = gen_instr();
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            out_ready = ($urandom_range(0, 99) < 60);
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(ref_cmd(in_instr, in_rs1_data, in_rs2_data));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        q.delete();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: got v=%0b want v=0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        @(negedge clk);
        in_instr = 32'h402081B3;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL arst_full: got v=%0b rdy=%0b want v=1 rdy=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL arst_immediate: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL arst_no_replay: got %0d stale cycles want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Decode-and-issue stage that drives the ALU's operand and select inputs. It accepts an RV32 instruction word plus register-file read data over a valid/ready handshake. It decodes the word into the 4-bit ALU select code, forms operand B (register or immediate), and presents a registered, back-pressurable command to the execute stage. Unsupported encodings are flagged as illegal rather than issued.

Parameters:
DATA_W, 32, operand and immediate width
SEL_W, 4, ALU select code width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction and operands valid
in_ready  out  1  stage can accept
in_instr  in  32  RV32 instruction word
in_rs1_data  in  DATA_W  register-file rs1 value
in_rs2_data  in  DATA_W  register-file rs2 value
out_valid  out  1  command valid
out_ready  in  1  execute stage accepts
out_rs1  out  DATA_W  ALU operand A
out_rs2  out  DATA_W  ALU operand B (rs2 or immediate)
out_alusel  out  SEL_W  ALU select code
out_rd  out  5  destination register
out_illegal  out  1  decode fault; sel and operands forced to 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n. On reset all output and skid registers clear to 0, out_valid=0 and in_ready=1.
- Select codes (shared package):
  - ADD=0, SLL=1, SLT=2, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=13, MUL=15.
- Decoding of opcode 0110011 (R-type), by funct7:
  - funct7=0000000 with funct3 in {0,1,2,4,5,6,7}: sel={0,funct3}.
  - funct7=0100000 with funct3=0: SUB.
  - funct7=0100000 with funct3=5: SRA.
  - funct7=0000001 with funct3=0: MUL.
  - All other combinations, including sltu (funct3=3): illegal.
  - Operand B is rs2_data.
- Decoding of opcode 0010011 (I-type ALU):
  - funct3 in {0,2,4,6,7}: sel={0,funct3}, operand B = sign-extended imm[11:0].
  - funct3=1 requires imm[11:5]=0000000: SLL.
  - funct3=5 with imm[11:5]=0000000: SRL; with 0100000: SRA.
  - For shifts, operand B = zero-extended shamt[4:0].
  - funct3=3 and bad shift funct7 are illegal.
- Decoding of opcode 0000011 (load): ADD, operand B = sign-extended I-imm, funct3 ignored.
- Decoding of opcode 0100011 (store): ADD, operand B = sign-extended S-imm {instr[31:25],instr[11:7]}, out_rd=0.
- Any other opcode is illegal. Illegal commands still issue (out_valid=1, out_illegal=1) with out_rd=0 and the other fields 0.
- Datapath: operand A is always rs1_data.
- Pipeline:
  - Main output register plus a one-entry skid register.
  - Latency: 1 cycle from input accept to out_valid.
  - Throughput: 1 per cycle while out_ready=1.
  - in_ready is registered: in_ready = !skid_full.
  - A transfer occurs when valid&&ready on the same edge.
- Boundary cases:
  - Output empty or draining, and input accepted: the input loads into the main register.
  - Output full and stalled (out_ready=0), and input accepted: the input loads into skid. in_ready falls the next cycle.
  - Output consumed while skid is full: skid moves into main, skid clears, in_ready rises the next cycle. No input is accepted that cycle because in_ready=0.
  - Order is strictly preserved. Outputs hold stable while out_valid&&!out_ready.
  - in_valid when in_ready=0: ignored, with no state change.
  - Reset mid-stream: pending commands are discarded and not replayed.

Decomposition:
- Package alu_issue_pkg holds:
  - ALU select localparams.
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE).
  - funct7 constants (F7_BASE, F7_ALT, F7_MUL).
- Sub-module alu_issue_decode: purely combinational, instr -> {sel, imm, use_imm, rd, illegal}.
- The top module holds the register/skid handshake.

Test Plan:
- Issue 0x002081B3 (add x3,x1,x2) with rs1=5, rs2=7 and out_ready=1 -> next cycle out_alusel=0, out_rs1=5, out_rs2=7, out_rd=3, out_illegal=0.
- Issue 0x40335293 (srai x5,x6,3) with rs1=0x80000000 -> out_alusel=13, out_rs2=3, out_rd=5.
- Issue 0x022081B3 (mul) -> out_alusel=15. Issue 0xFFF00093 (addi x1,x0,-1) -> out_alusel=0, out_rs2=0xFFFFFFFF, out_rd=1.
- Issue 0x0020B1B3 (sltu) -> out_valid=1, out_illegal=1, out_alusel=0, out_rs1=0, out_rs2=0, out_rd=0.
- Hold out_ready=0 and stream add, then sub (0x402081B3) -> in_ready drops after the second accept and out holds ADD. Release out_ready -> ADD, then SUB (sel=8) emerge in order, in_ready returns to 1, nothing is lost or duplicated.
- Assert rst_n=0 asynchronously between clock edges with both registers full -> out_valid=0 and in_ready=1 immediately. After release, no stale command appears.
